// File: rtl/sc_frog_mover.sv
// Frog position register and movement controller: row/one-hot column state,
// cooldown after user moves, and registered per-row frog buses.
// Optional river drift is compiled in with `define SC_FROGMOVER_DRIFT_EN.
module sc_frog_mover #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int HOLD_CYCLES   = 4,
  parameter int START_COL     = 3
) (
  input  logic                     SC_FROGMOVER_CLOCK_50,
  input  logic                     SC_FROGMOVER_RESET_InHigh,
  input  logic                     SC_FROGMOVER_START_In,
  input  logic                     SC_FROGMOVER_UP_In,
  input  logic                     SC_FROGMOVER_DOWN_In,
  input  logic                     SC_FROGMOVER_LEFT_In,
  input  logic                     SC_FROGMOVER_RIGHT_In,
  input  logic [1:0]               SC_FROGMOVER_SIDE_LOCATION_In_Bus,
  input  logic                     SC_FROGMOVER_HIT_In,
  input  logic                     SC_FROGMOVER_DRIFT_In,
  input  logic                     SC_FROGMOVER_DRIFT_DIR_In,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGMOVER_FROG_ROW_0_Out_Bus,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGMOVER_FROG_ROW_1_Out_Bus,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGMOVER_FROG_ROW_2_Out_Bus,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGMOVER_FROG_ROW_3_Out_Bus,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGMOVER_FROG_ROW_4_Out_Bus,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGMOVER_FROG_ROW_5_Out_Bus,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGMOVER_FROG_ROW_6_Out_Bus,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGMOVER_FROG_ROW_7_Out_Bus,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGMOVER_FROG_ROW_8_Out_Bus,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGMOVER_FROG_ROW_9_Out_Bus,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGMOVER_FROG_ROW_10_Out_Bus,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGMOVER_FROG_ROW_11_Out_Bus,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGMOVER_FROG_ROW_12_Out_Bus,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGMOVER_FROG_ROW_13_Out_Bus,
  output logic [2:0]               SC_FROGMOVER_STATE_Out_Bus,
  output logic                     SC_FROGMOVER_WIN_Out,
  output logic                     SC_FROGMOVER_DEAD_Out
);
  localparam int NUM_ROWS = 14;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [DATAWIDTH_BUS-1:0] START_VEC = DATAWIDTH_BUS'(1) << START_COL;

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_PLAY = 3'b001,
    S_HOLD = 3'b010,
    S_WIN  = 3'b011,
    S_DEAD = 3'b100
  } state_t;

  state_t                  state, nxt_state;
  logic [3:0]              row, nxt_row;
  logic [DATAWIDTH_BUS-1:0] col, nxt_col;
  logic [CW-1:0]           cnt, nxt_cnt;
  logic [NUM_ROWS-1:0][DATAWIDTH_BUS-1:0] row_bus;
  logic                    win_q, dead_q;

  // Edge decisions come from the side comparator, not from col itself.
  logic at_left, at_right;
  assign at_left  = (SC_FROGMOVER_SIDE_LOCATION_In_Bus == 2'b10);
  assign at_right = (SC_FROGMOVER_SIDE_LOCATION_In_Bus == 2'b01);

  logic                     drift_act, drift_off;
  logic [DATAWIDTH_BUS-1:0] drift_col;
`ifdef SC_FROGMOVER_DRIFT_EN
  assign drift_act = SC_FROGMOVER_DRIFT_In;
  assign drift_off = SC_FROGMOVER_DRIFT_In &&
                     (SC_FROGMOVER_DRIFT_DIR_In ? at_left : at_right);
  assign drift_col = SC_FROGMOVER_DRIFT_DIR_In ? (col << 1) : (col >> 1);
`else
  logic unused_drift;
  assign unused_drift = ^{SC_FROGMOVER_DRIFT_In, SC_FROGMOVER_DRIFT_DIR_In};
  assign drift_act = 1'b0;
  assign drift_off = 1'b0;
  assign drift_col = col;
`endif

  always_comb begin
    nxt_state = state;
    nxt_row   = row;
    nxt_col   = col;
    nxt_cnt   = cnt;
    case (state)
      S_IDLE: if (SC_FROGMOVER_START_In) nxt_state = S_PLAY;
      S_PLAY: begin
        if (SC_FROGMOVER_HIT_In) nxt_state = S_DEAD;
        else if (drift_act) begin
          if (drift_off) nxt_state = S_DEAD;
          else           nxt_col   = drift_col;
        end else if (SC_FROGMOVER_UP_In) begin
          nxt_row = row + 4'd1;
          if (row == 4'd12) nxt_state = S_WIN;
          else begin
            nxt_state = S_HOLD;
            nxt_cnt   = CNT_LOAD;
          end
        end else if (SC_FROGMOVER_DOWN_In) begin
          if (row != 4'd0) begin
            nxt_row   = row - 4'd1;
            nxt_state = S_HOLD;
            nxt_cnt   = CNT_LOAD;
          end
        end else if (SC_FROGMOVER_LEFT_In) begin
          if (!at_left) begin
            nxt_col   = col << 1;
            nxt_state = S_HOLD;
            nxt_cnt   = CNT_LOAD;
          end
        end else if (SC_FROGMOVER_RIGHT_In) begin
          if (!at_right) begin
            nxt_col   = col >> 1;
            nxt_state = S_HOLD;
            nxt_cnt   = CNT_LOAD;
          end
        end
      end
      S_HOLD: begin
        if (SC_FROGMOVER_HIT_In || drift_off) nxt_state = S_DEAD;
        else begin
          if (drift_act) nxt_col = drift_col;
          // User moves are discarded while cooling down.
          if (cnt == '0) nxt_state = S_PLAY;
          else           nxt_cnt   = cnt - CW'(1);
        end
      end
      S_WIN, S_DEAD: begin
        if (SC_FROGMOVER_START_In) begin
          nxt_state = S_PLAY;
          nxt_row   = 4'd0;
          nxt_col   = START_VEC;
          nxt_cnt   = '0;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge SC_FROGMOVER_CLOCK_50 or posedge SC_FROGMOVER_RESET_InHigh) begin
    if (SC_FROGMOVER_RESET_InHigh) begin
      state  <= S_IDLE;
      row    <= 4'd0;
      col    <= START_VEC;
      cnt    <= '0;
      win_q  <= 1'b0;
      dead_q <= 1'b0;
    end else begin
      state  <= nxt_state;
      row    <= nxt_row;
      col    <= nxt_col;
      cnt    <= nxt_cnt;
      win_q  <= (nxt_state == S_WIN) && (state != S_WIN);
      dead_q <= (nxt_state == S_DEAD);
    end
  end

  // Row buses are decoded from next-state values so the outputs are flops.
  always_ff @(posedge SC_FROGMOVER_CLOCK_50 or posedge SC_FROGMOVER_RESET_InHigh) begin
    if (SC_FROGMOVER_RESET_InHigh) begin
      row_bus    <= '0;
      row_bus[0] <= START_VEC;
    end else begin
      for (int k = 0; k < NUM_ROWS; k++)
        row_bus[k] <= (nxt_row == 4'(k)) ? nxt_col : '0;
    end
  end

  assign SC_FROGMOVER_FROG_ROW_0_Out_Bus  = row_bus[0];
  assign SC_FROGMOVER_FROG_ROW_1_Out_Bus  = row_bus[1];
  assign SC_FROGMOVER_FROG_ROW_2_Out_Bus  = row_bus[2];
  assign SC_FROGMOVER_FROG_ROW_3_Out_Bus  = row_bus[3];
  assign SC_FROGMOVER_FROG_ROW_4_Out_Bus  = row_bus[4];
  assign SC_FROGMOVER_FROG_ROW_5_Out_Bus  = row_bus[5];
  assign SC_FROGMOVER_FROG_ROW_6_Out_Bus  = row_bus[6];
  assign SC_FROGMOVER_FROG_ROW_7_Out_Bus  = row_bus[7];
  assign SC_FROGMOVER_FROG_ROW_8_Out_Bus  = row_bus[8];
  assign SC_FROGMOVER_FROG_ROW_9_Out_Bus  = row_bus[9];
  assign SC_FROGMOVER_FROG_ROW_10_Out_Bus = row_bus[10];
  assign SC_FROGMOVER_FROG_ROW_11_Out_Bus = row_bus[11];
  assign SC_FROGMOVER_FROG_ROW_12_Out_Bus = row_bus[12];
  assign SC_FROGMOVER_FROG_ROW_13_Out_Bus = row_bus[13];
  assign SC_FROGMOVER_STATE_Out_Bus       = state;
  assign SC_FROGMOVER_WIN_Out             = win_q;
  assign SC_FROGMOVER_DEAD_Out            = dead_q;
endmodule

// File: tb/tb_sc_frog_mover.sv
// Bench for sc_frog_mover: directed steps then random pulses, checked against
// a position/turn-counter model of the game rules.
module tb_sc_frog_mover;
  localparam int HOLD      = 4;
  localparam int START_COL = 3;
  localparam logic [7:0] ST = 8'h01, UP = 8'h02, DN = 8'h04, LF = 8'h08,
                         RT = 8'h10, HT = 8'h20, DR = 8'h40, DL = 8'h80;

  logic clk = 1'b0, rst = 1'b1;
  logic st, up, dn, lf, rt, hit, dr, dir;
  logic [1:0] side;
  logic [13:0][7:0] rows;
  logic [2:0] state_o;
  logic win_o, dead_o;
  int vectors = 0, miscompares = 0;

  // Reference model: row number, column as a bit position, cooldown turns left.
  int m_state, m_row, m_pos, m_left;
  bit m_win;

  always #5 clk = ~clk;

  sc_frog_mover #(.DATAWIDTH_BUS(8), .HOLD_CYCLES(HOLD), .START_COL(START_COL)) dut (
    .SC_FROGMOVER_CLOCK_50(clk), .SC_FROGMOVER_RESET_InHigh(rst),
    .SC_FROGMOVER_START_In(st), .SC_FROGMOVER_UP_In(up), .SC_FROGMOVER_DOWN_In(dn),
    .SC_FROGMOVER_LEFT_In(lf), .SC_FROGMOVER_RIGHT_In(rt),
    .SC_FROGMOVER_SIDE_LOCATION_In_Bus(side), .SC_FROGMOVER_HIT_In(hit),
    .SC_FROGMOVER_DRIFT_In(dr), .SC_FROGMOVER_DRIFT_DIR_In(dir),
    .SC_FROGMOVER_FROG_ROW_0_Out_Bus(rows[0]),   .SC_FROGMOVER_FROG_ROW_1_Out_Bus(rows[1]),
    .SC_FROGMOVER_FROG_ROW_2_Out_Bus(rows[2]),   .SC_FROGMOVER_FROG_ROW_3_Out_Bus(rows[3]),
    .SC_FROGMOVER_FROG_ROW_4_Out_Bus(rows[4]),   .SC_FROGMOVER_FROG_ROW_5_Out_Bus(rows[5]),
    .SC_FROGMOVER_FROG_ROW_6_Out_Bus(rows[6]),   .SC_FROGMOVER_FROG_ROW_7_Out_Bus(rows[7]),
    .SC_FROGMOVER_FROG_ROW_8_Out_Bus(rows[8]),   .SC_FROGMOVER_FROG_ROW_9_Out_Bus(rows[9]),
    .SC_FROGMOVER_FROG_ROW_10_Out_Bus(rows[10]), .SC_FROGMOVER_FROG_ROW_11_Out_Bus(rows[11]),
    .SC_FROGMOVER_FROG_ROW_12_Out_Bus(rows[12]), .SC_FROGMOVER_FROG_ROW_13_Out_Bus(rows[13]),
    .SC_FROGMOVER_STATE_Out_Bus(state_o), .SC_FROGMOVER_WIN_Out(win_o),
    .SC_FROGMOVER_DEAD_Out(dead_o));

  // Side comparator stand-in: looks at the frog buses like the real one.
  logic [7:0] any_col;
  always_comb begin
    any_col = '0;
    for (int k = 0; k < 14; k++) any_col = any_col | rows[k];
  end
  assign side = {any_col[7], any_col[0]};

  task automatic model_reset();
    m_state = 0; m_row = 0; m_pos = START_COL; m_left = 0; m_win = 0;
  endtask

  // Returns 1 if the drift kills the frog, else moves it.
  function automatic bit model_drift(input bit d);
    if (d ? (m_pos == 7) : (m_pos == 0)) return 1'b1;
    m_pos = d ? m_pos + 1 : m_pos - 1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic [7:0] in);
    bit drift_on;
`ifdef SC_FROGMOVER_DRIFT_EN
    drift_on = in[6];
`else
    drift_on = 1'b0;
`endif
    m_win = 0;
    case (m_state)
      0: if (in[0]) m_state = 1;
      1: begin
        if (in[5]) m_state = 4;
        else if (drift_on) begin
          if (model_drift(in[7])) m_state = 4;
        end else if (in[1]) begin
          m_row++;
          if (m_row == 13) begin m_state = 3; m_win = 1; end
          else begin m_state = 2; m_left = HOLD; end
        end else if (in[2]) begin
          if (m_row > 0) begin m_row--; m_state = 2; m_left = HOLD; end
        end else if (in[3]) begin
          if (m_pos < 7) begin m_pos++; m_state = 2; m_left = HOLD; end
        end else if (in[4]) begin
          if (m_pos > 0) begin m_pos--; m_state = 2; m_left = HOLD; end
        end
      end
      2: begin
        if (in[5]) m_state = 4;
        else if (drift_on && model_drift(in[7])) m_state = 4;
        else begin
          m_left--;
          if (m_left == 0) m_state = 1;
        end
      end
      default: if (in[0]) begin m_state = 1; m_row = 0; m_pos = START_COL; end
    endcase
  endtask

  function automatic logic [13:0][7:0] exp_rows();
    logic [13:0][7:0] r;
    for (int k = 0; k < 14; k++) r[k] = (k == m_row) ? 8'(1 << m_pos) : 8'h00;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [111:0] obs, input logic [111:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 112'(state_o), 112'(m_state));
    chk("rows",  112'(rows),    112'(exp_rows()));
    chk("win",   112'(win_o),   112'(m_win));
    chk("dead",  112'(dead_o),  112'(m_state == 4));
  endtask

  task automatic cycle(input logic [7:0] in);
    {dir, dr, hit, rt, lf, dn, up, st} = in;
    @(posedge clk);
    model_step(in);
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    {dir, dr, hit, rt, lf, dn, up, st} = '0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    {dir, dr, hit, rt, lf, dn, up, st} = '0;
    model_reset();
    do_reset();
    // Start, accepted LEFT, ignored LEFT during cooldown, back to PLAY.
    cycle(ST); cycle(LF); idle(1); cycle(LF); idle(3);
    // Walk to the left edge, blocked LEFT, then accepted RIGHT.
    cycle(LF); idle(4); cycle(LF); idle(4); cycle(LF); idle(4);
    cycle(LF); cycle(RT); idle(4);
    // Climb to row 13 with UP pulses 6 cycles apart, then restart.
    do_reset(); cycle(ST);
    for (int i = 0; i < 13; i++) begin cycle(UP); idle(5); end
    cycle(ST); idle(1);
    // HIT during cooldown, moves ignored while dead, restart.
    cycle(UP); cycle(HT); cycle(LF); cycle(UP); idle(2); cycle(ST); idle(1);
    // Right edge then drift right off the edge (no effect without drift).
    cycle(RT); idle(4); cycle(RT); idle(4); cycle(RT); idle(4);
    cycle(RT); cycle(DR); idle(2); cycle(ST); idle(1);
    // Drift left inside the board, then drift with a simultaneous move.
    cycle(DR | DL); idle(1); cycle(DR | DL | UP); idle(1);
    // Reset mid-cooldown, then UP+LEFT together takes only the UP.
    cycle(LF); idle(1); do_reset(); cycle(ST); cycle(UP | LF); idle(4);
    // Random pulses.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] in;
      in = '0;
      if ($urandom_range(0, 39) == 0) in |= ST;
      if ($urandom_range(0, 5) == 0)  in |= UP;
      if ($urandom_range(0, 7) == 0)  in |= DN;
      if ($urandom_range(0, 4) == 0)  in |= LF;
      if ($urandom_range(0, 4) == 0)  in |= RT;
      if ($urandom_range(0, 79) == 0) in |= HT;
      if ($urandom_range(0, 9) == 0)  in |= DR;
      if ($urandom_range(0, 1) == 0)  in |= DL;
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle(in);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
